// File: rtl/ahb_apb_bridge_mp.sv
`default_nettype none
// ============================================================================
// ahb_apb_bridge_mp: AHB-Lite slave to NUM_SLV-port APB4 master bridge. Rev 1.0
// ============================================================================
module ahb_apb_bridge_mp #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSELAPBif,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HSIZE,
    input  logic                    HWRITE,
    input  logic                    HREADYin,
    input  logic [ADDR_W-1:0]       HADDR,
    input  logic [DATA_W-1:0]       HWDATA,
    output logic                    HREADYout,
    output logic [1:0]              HRESP,
    output logic [DATA_W-1:0]       HRDATA,
    output logic [ADDR_W-1:0]       PADDR,
    output logic [NUM_SLV-1:0]      PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [DATA_W-1:0]       PWDATA,
    output logic [DATA_W/8-1:0]     PSTRB,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]      PREADY,
    input  logic [NUM_SLV-1:0]      PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int SLOTS  = 1 << IDX_W;
    // Bit i set when index value i names an existing slave.
    localparam logic [SLOTS-1:0] SLV_OK  = {SLOTS{1'b1}} >> (SLOTS - NUM_SLV);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx_q;
    logic [TO_W-1:0]     cnt;
    logic                valid;
    logic                decode_err;
    logic [IDX_W-1:0]    req_idx;
    logic                sel_ready;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic                unused_htrans;

    function automatic logic [LANE_W-1:0] size_mask(input logic [2:0] size);
        return LANE_W'((32'd1 << size) - 32'd1);
    endfunction

    function automatic logic [STRB_W-1:0] lane_strb(input logic [2:0] size,
                                                     input logic [LANE_W-1:0] off);
        logic [STRB_W-1:0] m;
        m = STRB_W'((32'd1 << (32'd1 << size)) - 32'd1);
        return m << off;
    endfunction

    function automatic logic [NUM_SLV-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_SLV-1:0] o;
        for (int i = 0; i < NUM_SLV; i++) begin
            o[i] = (idx == IDX_W'(i));
        end
        return o;
    endfunction

    assign unused_htrans = HTRANS[0];
    assign valid         = HSELAPBif & HREADYin & HTRANS[1];
    assign req_idx       = HADDR[SEL_LSB +: IDX_W];
    assign decode_err    = !SLV_OK[req_idx] || (HSIZE > 3'(LANE_W)) ||
                           ((HADDR[LANE_W-1:0] & size_mask(HSIZE)) != '0);

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdata = PRDATA[i*DATA_W +: DATA_W];
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            idx_q     <= '0;
            cnt       <= '0;
            HREADYout <= 1'b1;
            HRESP     <= 2'b00;
            HRDATA    <= '0;
            PADDR     <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
        end else begin
            case (state)
                // ERR2 is the ready half of the error response, so it accepts like IDLE.
                IDLE, ERR2: begin
                    HRESP     <= 2'b00;
                    HREADYout <= 1'b1;
                    state     <= IDLE;
                    if (valid) begin
                        HREADYout <= 1'b0;
                        if (decode_err) begin
                            HRESP <= 2'b01;
                            state <= ERR1;
                        end else begin
                            idx_q  <= req_idx;
                            PADDR  <= HADDR;
                            PWRITE <= HWRITE;
                            if (HWRITE) begin
                                PSTRB <= lane_strb(HSIZE, HADDR[LANE_W-1:0]);
                                state <= WDATA;
                            end else begin
                                PSTRB <= '0;
                                PSEL  <= onehot(req_idx);
                                cnt   <= '0;
                                state <= SETUP;
                            end
                        end
                    end
                end
                WDATA: begin
                    PWDATA <= HWDATA;
                    PSEL   <= onehot(idx_q);
                    cnt    <= '0;
                    state  <= SETUP;
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (sel_err) begin
                            HRESP <= 2'b01;
                            state <= ERR1;
                        end else begin
                            if (!PWRITE) begin
                                HRDATA <= sel_rdata;
                            end
                            HREADYout <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + TO_W'(1);
                        if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                            PSEL    <= '0;
                            PENABLE <= 1'b0;
                            HRESP   <= 2'b01;
                            state   <= ERR1;
                        end
                    end
                end
                ERR1: begin
                    HREADYout <= 1'b1;
                    state     <= ERR2;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ahb_apb_bridge_mp.md
Name: ahb_apb_bridge_mp

Overview:
AHB-Lite slave to APB4 master bridge. It is the parametrised successor of the single-slave AHB-to-APB bridge. It serves NUM_SLV APB slaves with per-slave PSEL, PSTRB generation, PSLVERR-to-HRESP mapping and a PREADY timeout. It sits between the AHB interconnect (HSELAPBif decode) and the peripheral APB segment.

Parameters:
ADDR_W, 32, AHB/APB address width
DATA_W, 32, data width; legal values 32 or 64
NUM_SLV, 4, number of APB slaves (1..16)
SEL_LSB, 12, lowest HADDR bit of the slave index field; field width is clog2(NUM_SLV), minimum 1
TIMEOUT, 255, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout
TO_W, 8, width of the timeout counter; TIMEOUT must be less than 2^TO_W

Ports:
HCLK in 1 clock, rising edge
HRESETn in 1 asynchronous active-low reset
HSELAPBif in 1 bridge select from the AHB decoder
HTRANS in 2 IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HSIZE in 3 transfer size (bytes = 2^HSIZE)
HWRITE in 1 1 = write
HREADYin in 1 bus HREADY
HADDR in ADDR_W address
HWDATA in DATA_W write data (data phase)
HREADYout out 1 bridge ready
HRESP out 2 00 = OKAY, 01 = ERROR
HRDATA out DATA_W read data
PADDR out ADDR_W APB address
PSEL out NUM_SLV one-hot slave select
PENABLE out 1 APB access phase
PWRITE out 1 APB direction
PWDATA out DATA_W APB write data
PSTRB out DATA_W/8 byte strobes
PRDATA in NUM_SLV*DATA_W per-slave read data; slave i occupies slice [i*DATA_W +: DATA_W]
PREADY in NUM_SLV per-slave ready
PSLVERR in NUM_SLV per-slave error

Behaviour:
- Reset (asynchronous, any state): state = IDLE, HREADYout = 1, HRESP = 00, HRDATA = 0, PADDR = 0, PSEL = 0, PENABLE = 0, PWRITE = 0, PWDATA = 0, PSTRB = 0, timeout counter = 0. A reset mid-transfer drops PSEL/PENABLE immediately; no APB completion follows.
- All outputs are registered.
- Valid transfer: HSELAPBif & HREADYin & HTRANS[1] at a rising edge. On it the bridge captures HADDR, HWRITE, HSIZE and the slave index idx = HADDR[SEL_LSB +: clog2(NUM_SLV)]. BUSY and IDLE are ignored.
- Decode error, detected at capture, causes a transfer to take the ERR1 path:
  - idx >= NUM_SLV;
  - 2^HSIZE > DATA_W/8;
  - HADDR not aligned to 2^HSIZE.
  - No APB cycle is issued for a decode error.
- States:
  - IDLE: HREADYout = 1. A valid read goes to SETUP. A valid write goes to WDATA. A decode error goes to ERR1. Otherwise stay in IDLE.
  - WDATA (write only): HREADYout = 0. At the edge, PWDATA <= HWDATA; go to SETUP.
  - SETUP: PSEL[idx] = 1, PENABLE = 0, PADDR and PWRITE valid. PSTRB = byte lanes covered by HSIZE at HADDR[clog2(DATA_W/8)-1:0] for writes, and all zero for reads. Go to ACCESS.
  - ACCESS: PENABLE = 1; the timeout counter increments each cycle while PREADY[idx] = 0.
    - PREADY[idx] & !PSLVERR[idx]: HRDATA <= PRDATA[idx] (reads only), HREADYout <= 1, PSEL/PENABLE <= 0; go to IDLE.
    - PREADY[idx] & PSLVERR[idx]: go to ERR1.
    - Counter reaches TIMEOUT (with TIMEOUT != 0): drop PSEL/PENABLE; go to ERR1.
  - ERR1: HREADYout = 0, HRESP = 01, PSEL = 0. Go to ERR2.
  - ERR2: HREADYout = 1, HRESP = 01. A valid transfer sampled here is accepted exactly as in IDLE. Otherwise go to IDLE with HRESP = 00.
- Latency:
  - Zero-wait read: HREADYout low for 2 data-phase cycles.
  - Zero-wait write: HREADYout low for 3 data-phase cycles.
  - Each PREADY-low cycle adds 1.
- Back-to-back: a transfer presented during the HREADYout = 1 cycle that ends a previous transfer is captured; there is no dead cycle.
- PREADY and PSLVERR of unselected slaves are ignored. PSEL is never multi-hot.
- PWDATA and PADDR hold their value from SETUP until the next capture.
- The timeout counter clears on every entry to SETUP.

Test Plan:
1. Read, NONSEQ, HADDR = 0x0000_2004 with SEL_LSB = 12 -> PSEL = 0100, PSTRB = 0. Slave 2 gives PREADY = 1, PRDATA = 0xA5A5_1234 -> HRDATA = 0xA5A5_1234, HRESP = 00, HREADYout low for 2 cycles.
2. Byte write, HSIZE = 0, HADDR = 0x0000_1003, HWDATA = 0x1100_0000 -> PSEL = 0010, PSTRB = 1000, PWDATA = 0x1100_0000, PWRITE = 1. PREADY is held low 3 cycles -> HREADYout low for 6 cycles.
3. Slave returns PSLVERR = 1 with PREADY -> ERR1 (HREADYout = 0, HRESP = 01), then ERR2 (HREADYout = 1, HRESP = 01), then OKAY.
4. Misaligned word at HADDR = 0x0000_0002 -> no PSEL asserted, two-cycle ERROR. Then NUM_SLV = 3 with HADDR = 0x0000_3000 -> decode ERROR.
5. TIMEOUT = 4 with PREADY stuck low -> PSEL drops after 4 ACCESS cycles, then ERROR response.
6. Two NONSEQ reads back-to-back to slaves 0 and 1 -> second SETUP follows the first completion with no IDLE gap. Assert HRESETn during the second ACCESS -> all outputs return to reset values immediately.
